// File: rtl/parallel_to_serial_if.sv
// Handshake and serial-line bundle for parallel_to_serial.
// The master (word source) drives data_in/load_valid; the slave drives everything else.
interface parallel_to_serial_if #(
  parameter int N = 8
);
  logic [N-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         serial_out;
  logic         frame_start;
  logic         done_tick;
  logic         busy;

  modport master (
    output data_in, load_valid,
    input  load_ready, serial_out, frame_start, done_tick, busy
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, serial_out, frame_start, done_tick, busy
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter with one-entry holding buffer for gapless framing.
// Define PARALLEL_TO_SERIAL_MSB_FIRST_EN to send bit N-1 first; the default sends bit 0 first.
module parallel_to_serial #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  parallel_to_serial_if.slave  bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            accept;
  logic            out_bit;

  function automatic logic [N-1:0] shift_once(input logic [N-1:0] v);
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
    return {v[N-2:0], 1'b0};
`else
    return {1'b0, v[N-1:1]};
`endif
  endfunction

`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
  assign out_bit = sr_q[N-1];
`else
  assign out_bit = sr_q[0];
`endif

  assign bus.load_ready  = ~buf_full_q;
  assign accept          = bus.load_valid && ~buf_full_q;
  assign bus.busy        = (state_q == SHIFT);
  assign bus.serial_out  = (state_q == SHIFT) ? out_bit : 1'b0;
  assign bus.frame_start = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.done_tick   = (state_q == SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sr_d  = shift_once(sr_q);
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            buf_d      = bus.data_in;
            buf_full_d = 1'b1;
          end
        end else if (buf_full_q) begin
          // Last bit: buffered word takes over on the next cycle, no idle gap.
          sr_d       = buf_q;
          buf_full_d = 1'b0;
          cnt_d      = '0;
        end else if (accept) begin
          sr_d  = bus.data_in;
          cnt_d = '0;
        end else begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Buffer contents are only meaningful while buf_full_q is set.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end
endmodule
